muldiv_iter: RTL and testbench

- Iterative RV32M multiply/divide unit, companion to the single-cycle integer ALU in the execute stage.
- Takes the same operand/fun3 style of request (op1, op2, fun3) for OPCODE_OP with funct7=0000001.
- Produces a 32-bit result over a valid/ready handshake so the pipeline can stall on it.
- One operation in flight; radix-2 shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/muldiv_iter.sv | 158 +++++++++++++++
 tb/tb_muldiv_iter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, one operation in flight, valid/ready on both sides.
module muldiv_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [2:0]      fun3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       fun3_q, fun3_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]  m_q, m_d, lo_q, lo_d, res_q, res_d;
  logic [XLEN:0]    hi_q, hi_d;
  logic             negq_q, negq_d, negr_q, negr_d;

  logic             sgn1, sgn2;
  logic [XLEN-1:0]  mag1, mag2;
  logic [XLEN:0]    mul_sum, div_t;
  logic [XLEN+1:0]  div_diff;
  logic [2*XLEN-1:0] prod_raw, prod;
  logic [XLEN-1:0]  quo, rem;
  logic             div_zero, div_ovf;

  assign sgn1 = op1[XLEN-1] & ((fun3 == 3'b001) || (fun3 == 3'b010) ||
                               (fun3 == 3'b100) || (fun3 == 3'b110));
  assign sgn2 = op2[XLEN-1] & ((fun3 == 3'b001) || (fun3 == 3'b100) || (fun3 == 3'b110));
  assign mag1 = sgn1 ? -op1 : op1;
  assign mag2 = sgn2 ? -op2 : op2;

  // hi_q is the running product high half for multiply, the partial remainder for divide
  assign mul_sum  = hi_q + (lo_q[0] ? {1'b0, m_q} : '0);
  assign div_t    = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
  assign div_diff = {1'b0, div_t} - {2'b00, m_q};

  assign prod_raw = {hi_q[XLEN-1:0], lo_q};
  assign prod     = negq_q ? -prod_raw : prod_raw;
  assign quo      = negq_q ? -lo_q : lo_q;
  assign rem      = negr_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];

  assign div_zero = fun3_q[2] && (b_q == '0);
  assign div_ovf  = fun3_q[2] && !fun3_q[0] && (a_q == INT_MIN) && (b_q == '1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fun3_d  = fun3_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    res_d   = res_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          state_d = S_CALC;
          cnt_d   = '0;
          fun3_d  = fun3;
          a_d     = op1;
          b_d     = op2;
          m_d     = fun3[2] ? mag2 : mag1;
          lo_d    = fun3[2] ? mag1 : mag2;
          hi_d    = '0;
          negq_d  = sgn1 ^ sgn2;
          negr_d  = sgn1;
        end
      end
      S_CALC: begin
        // special divides are resolved on the first CALC edge instead of iterating
        if ((cnt_q == '0) && (div_zero || div_ovf)) begin
          state_d = S_DONE;
          if (div_zero) res_d = fun3_q[1] ? a_q : '1;
          else          res_d = fun3_q[1] ? '0 : INT_MIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fun3_q[2]) begin
            if (!div_diff[XLEN+1]) begin
              hi_d = div_diff[XLEN:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = div_t;
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = {1'b0, mul_sum[XLEN:1]};
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == '1) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (fun3_q[2])                res_d = fun3_q[1] ? rem : quo;
        else if (fun3_q[1:0] == 2'b00) res_d = prod[XLEN-1:0];
        else                          res_d = prod[2*XLEN-1:XLEN];
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fun3_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      res_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fun3_q  <= fun3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      res_q   <= res_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: arithmetic reference model plus a timing scoreboard,
// compared against the DUT every cycle; directed corner cases then random traffic.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1, op2;
  logic [2:0]  fun3;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  muldiv_iter #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .fun3(fun3), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        bp_rand = 1'b0;
  logic        ev;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (bp_rand) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f);
    longint      sa, sb, sp;
    logic [63:0] up;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (f)
      3'd0: begin sp = sa * sb; r = sp[31:0]; end
      3'd1: begin sp = sa * sb; r = sp[63:32]; end
      3'd2: begin sp = sa * longint'({32'b0, b}); r = sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      3'd4: if (b == 0) r = '1; else begin sp = sa / sb; r = sp[31:0]; end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a; else begin sp = sa % sb; r = sp[31:0]; end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int unsigned latency(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
    if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Per-cycle comparison: out_valid timing, idle/busy, and the result while valid
  always @(negedge clk) begin
    ev = 1'b0;
    if (q.size() > 0) ev = (cyc >= q[0].due);
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
    if (ev && out_valid) begin
      chk("result", result, q[0].res);
      if (out_ready && !flush) void'(q.pop_front());
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                       input logic [31:0] exp);
    int unsigned n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op1 = a; op2 = b; fun3 = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    q.push_back('{res: exp, due: cyc + latency(a, b, f)});
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] da  [12] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                            32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C,
                            32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] db  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2,
                            32'd7, 32'd7, 32'd7, 32'd7,
                            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [2:0]  df  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd7, 3'd4, 3'd6,
                            3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] dex [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF,
                            32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE,
                            32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0]  f;
    int unsigned n;
    rst_n = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0; fun3 = '0;
    flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pin the reference model to hand-computed values, then run the same cases on the DUT
    for (int i = 0; i < 12; i++) chk("model_pin", model(da[i], db[i], df[i]), dex[i]);
    for (int i = 0; i < 12; i++) begin
      issue(da[i], db[i], df[i], dex[i]);
      wait_done();
    end

    // Backpressure: result held for 10 cycles while in_valid is ignored
    out_ready = 1'b0;
    issue(32'd9, 32'd11, 3'd0, 32'd99);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    in_valid = 1'b1; op1 = 32'd5; op2 = 32'd6; fun3 = 3'd0;
    repeat (10) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done();

    // Flush at count 10
    issue(32'h1234_5678, 32'h0000_0F0F, 3'd5, 32'h1234_5678 / 32'h0000_0F0F);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    q.delete();
    repeat (3) begin @(posedge clk); #1; end

    // Reset at count 20 on a second operation
    issue(32'hDEAD_BEEF, 32'h0000_1234, 3'd0, 32'hDEAD_BEEF * 32'h0000_1234);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("midop_rst_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(32'd3, 32'd5, 3'd0, 32'd15);
    wait_done();

    // Flush together with in_valid in IDLE must not accept
    in_valid = 1'b1; flush = 1'b1; op1 = 32'd1; op2 = 32'd1; fun3 = 3'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Random traffic with random backpressure and occasional flushes
    bp_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = pick(); b = pick(); f = 3'($urandom_range(0, 7));
      issue(a, b, f, model(a, b, f));
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        q.delete();
      end else begin
        wait_done();
      end
    end
    bp_rand = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
